// File: rtl/key_scan.sv
// key_scan: 4x4 key matrix scanner with row drive, column debounce, one-clock strobe and held level.
// Define KEY_REPEAT_EN to add auto-repeat strobes while a key stays held.
module key_scan #(
    parameter int CLK_Freq     = 100000000,
    parameter int SCAN_Freq    = 1000,
    parameter int DB_TICKS     = 10,
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100
) (
    input  logic       CP_100MHz,
    input  logic       nCLR,
    input  logic [3:0] COL,
    output logic [3:0] ROW,
    output logic [3:0] KEY,
    output logic       KEY_VALID,
    output logic       KEY_DOWN
);
    localparam int DIV = CLK_Freq / SCAN_Freq;
    localparam int DW  = $clog2(DIV);
    localparam logic [1:0] SCAN = 2'd0, DEBOUNCE = 2'd1, HELD = 2'd2;

    if (DIV < 4 || DB_TICKS < 1 || DB_TICKS > 255 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_params
        $error("key_scan: parameter out of range");
    end

    logic [DW-1:0] div;
    logic          tick;
    logic [3:0]    col_m, col_s;
    logic [1:0]    state, r, c, c_new, key_c;
    logic [7:0]    dbcnt, relcnt;
    logic          pressed, col_hit, accept, release_done, rpt_fire;

    assign tick         = div == DW'(DIV - 1);
    assign ROW          = ~(4'b0001 << r);
    assign pressed      = ~&col_s;
    assign c_new        = ~col_s[0] ? 2'd0 : ~col_s[1] ? 2'd1 : ~col_s[2] ? 2'd2 : 2'd3;
    assign col_hit      = ~col_s[c];
    assign key_c        = state == SCAN ? c_new : c;
    // The detection tick already counts as the first match, so DB_TICKS=1 accepts straight from SCAN.
    assign accept       = tick && ((state == SCAN && pressed && DB_TICKS == 1) ||
                                   (state == DEBOUNCE && col_hit && dbcnt + 8'd1 == 8'(DB_TICKS)));
    assign release_done = !col_hit && relcnt + 8'd1 == 8'(DB_TICKS);

`ifdef KEY_REPEAT_EN
    logic [15:0] rptcnt;
    logic        rpt_first;

    assign rpt_fire = tick && state == HELD && col_hit &&
                      rptcnt + 16'd1 == (rpt_first ? 16'(REPEAT_DELAY) : 16'(REPEAT_RATE));

    always_ff @(posedge CP_100MHz or negedge nCLR) begin
        if (!nCLR) begin
            rptcnt    <= '0;
            rpt_first <= 1'b1;
        end else if (tick) begin
            if (state != HELD || !col_hit) begin
                rptcnt    <= '0;
                rpt_first <= 1'b1;
            end else if (rpt_fire) begin
                rptcnt    <= '0;
                rpt_first <= 1'b0;
            end else
                rptcnt <= rptcnt + 16'd1;
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    always_ff @(posedge CP_100MHz or negedge nCLR) begin
        if (!nCLR) begin
            div       <= '0;
            col_m     <= 4'hF;
            col_s     <= 4'hF;
            state     <= SCAN;
            r         <= '0;
            c         <= '0;
            dbcnt     <= '0;
            relcnt    <= '0;
            KEY       <= '0;
            KEY_VALID <= 1'b0;
            KEY_DOWN  <= 1'b0;
        end else begin
            col_m     <= COL;
            col_s     <= col_m;
            div       <= tick ? '0 : div + 1'b1;
            KEY_VALID <= accept || rpt_fire;
            if (tick) begin
                if (state == SCAN) begin
                    if (pressed) begin
                        c     <= c_new;
                        dbcnt <= 8'd1;
                        state <= DEBOUNCE;
                    end else
                        r <= r + 2'd1;
                end else if (state == DEBOUNCE) begin
                    if (col_hit)
                        dbcnt <= dbcnt + 8'd1;
                    else begin
                        state <= SCAN;
                        r     <= r + 2'd1;
                    end
                end else if (release_done) begin
                    relcnt   <= '0;
                    KEY_DOWN <= 1'b0;
                    r        <= r + 2'd1;
                    state    <= SCAN;
                end else
                    relcnt <= col_hit ? '0 : relcnt + 8'd1;
                if (accept) begin
                    KEY      <= {r, key_c};
                    KEY_DOWN <= 1'b1;
                    relcnt   <= '0;
                    state    <= HELD;
                end
            end
        end
    end
endmodule

// File: tb/tb_key_scan.sv
// tb_key_scan: self-checking bench for key_scan with a virtual 4x4 keypad and a tick-level reference model.
module tb_key_scan;
    localparam int TCLK = 10, DB = 3, RD = 5, RR = 2;
`ifdef KEY_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif
    localparam logic [15:0] K9 = 16'h0200, K15 = 16'h8000;

    logic        clk = 1'b0, nclr = 1'b0;
    logic [3:0]  col, row, key, e_row, e_key;
    logic        key_valid, key_down, e_valid, e_down;
    logic [15:0] keys = '0;
    int n_vec = 0, n_err = 0, exp_pulses = 0, dut_pulses = 0;
    int m_cnt, m_row, m_cand, m_streak, m_up, m_hold;
    bit m_tick, m_locked, m_held;

    always #5 clk = ~clk;

    key_scan #(.CLK_Freq(1000), .SCAN_Freq(100), .DB_TICKS(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
        .CP_100MHz(clk), .nCLR(nclr), .COL(col), .ROW(row),
        .KEY(key), .KEY_VALID(key_valid), .KEY_DOWN(key_down)
    );

    // Physical keypad: a pressed key shorts its column to whichever row is driven low.
    always_comb begin
        col = 4'hF;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (!row[i] && keys[i*4+j]) col[j] = 1'b0;
    end

    assign e_row = ~(4'b0001 << m_row);

    // Reference model: works on whole keys and run lengths of ticks.
    task automatic model_tick();
        int lo;
        if (!m_locked) begin
            lo = -1;
            for (int j = 3; j >= 0; j--) if (keys[m_row*4+j]) lo = j;
            if (lo < 0) m_row = (m_row + 1) % 4;
            else begin
                m_locked = 1; m_cand = m_row * 4 + lo; m_streak = 1;
            end
        end else if (!m_held) begin
            if (keys[m_cand]) m_streak++;
            else begin
                m_locked = 0; m_row = (m_row + 1) % 4;
            end
        end else if (keys[m_cand]) begin
            m_up = 0; m_hold++;
            if (m_hold == RD || (m_hold > RD && (m_hold - RD) % RR == 0)) e_valid = REP;
        end else begin
            m_up++; m_hold = 0;
            if (m_up == DB) begin
                m_held = 0; m_locked = 0; e_down = 0; m_row = (m_row + 1) % 4;
            end
        end
        if (m_locked && !m_held && m_streak == DB) begin
            m_held = 1; m_up = 0; m_hold = 0;
            e_key = 4'(m_cand); e_valid = 1; e_down = 1;
        end
    endtask

    always @(posedge clk or negedge nclr) begin
        if (!nclr) begin
            m_cnt = 0; m_row = 0; m_cand = 0; m_streak = 0; m_up = 0; m_hold = 0;
            m_tick = 0; m_locked = 0; m_held = 0;
            e_key = '0; e_valid = 1'b0; e_down = 1'b0;
        end else begin
            m_tick = (m_cnt == TCLK - 1);
            m_cnt = m_tick ? 0 : m_cnt + 1;
            e_valid = 1'b0;
            if (m_tick) model_tick();
            if (e_valid) exp_pulses++;
        end
    end

    always @(posedge clk) if (key_valid) dut_pulses++;

    task automatic next_tick();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!m_tick && n < 4 * TCLK);
        if (!m_tick) begin
            n_vec++; n_err++;
            $display("FAIL tick_timeout: no tick within %0d clocks", n);
        end
    endtask

    task automatic test_reset();
        nclr = 1'b0; keys = '0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (row !== 4'b1110) begin n_err++; $display("FAIL reset_row: got %b expected 1110", row); end
        n_vec++;
        if ({key, key_valid, key_down} !== 6'b0) begin
            n_err++; $display("FAIL reset_outs: got key=%h valid=%b down=%b expected 0/0/0", key, key_valid, key_down);
        end
        nclr = 1'b1;
    endtask

    task automatic test_idle_scan();
        logic [3:0] exp;
        int p0 = dut_pulses;
        keys = '0;
        for (int i = 1; i <= 8; i++) begin
            next_tick();
            exp = ~(4'b0001 << (i % 4));
            n_vec++;
            if (row !== exp) begin n_err++; $display("FAIL idle_row: tick %0d got %b expected %b", i, row, exp); end
            repeat (5) @(negedge clk);
            n_vec++;
            if (row !== exp) begin n_err++; $display("FAIL idle_row_hold: tick %0d got %b expected %b", i, row, exp); end
        end
        n_vec++;
        if (dut_pulses != p0) begin n_err++; $display("FAIL idle_valid: got %0d strobes expected 0", dut_pulses - p0); end
    endtask

    task automatic test_press();
        int p0 = dut_pulses;
        keys = K9;
        for (int i = 0; i < 10; i++) begin
            next_tick();
            n_vec++;
            if ({row, key_valid, key_down} !== {e_row, e_valid, e_down}) begin
                n_err++;
                $display("FAIL press_step: tick %0d got row=%b valid=%b down=%b expected row=%b valid=%b down=%b",
                         i, row, key_valid, key_down, e_row, e_valid, e_down);
            end
        end
        repeat (3) @(negedge clk);
        n_vec++;
        if ({row, key, key_down} !== {4'b1011, 4'd9, 1'b1}) begin
            n_err++; $display("FAIL press_final: got row=%b key=%0d down=%b expected 1011/9/1", row, key, key_down);
        end
        n_vec++;
        if (dut_pulses - p0 != 1) begin n_err++; $display("FAIL press_strobes: got %0d expected 1", dut_pulses - p0); end
    endtask

    task automatic test_release_bounce();
        logic [4:0] pat = 5'b00010;
        logic [4:0] exp_down = 5'b01111;
        for (int i = 0; i < 5; i++) begin
            keys = pat[i] ? K9 : '0;
            next_tick();
            n_vec++;
            if (key_down !== exp_down[i]) begin
                n_err++; $display("FAIL release_down: step %0d got %b expected %b", i, key_down, exp_down[i]);
            end
        end
        n_vec++;
        if ({row, key} !== {4'b0111, 4'd9}) begin
            n_err++; $display("FAIL release_row: got row=%b key=%0d expected 0111/9", row, key);
        end
    endtask

    task automatic test_bounce();
        int n = 0;
        int p0;
        keys = K9;
        do begin next_tick(); n++; end while (!m_locked && n < 8);
        p0 = dut_pulses;
        keys = '0;
        next_tick();
        n_vec++;
        if ({key_valid, key_down} !== 2'b00) begin
            n_err++; $display("FAIL bounce_glitch: got valid=%b down=%b expected 0/0", key_valid, key_down);
        end
        keys = K9;
        repeat (3) @(negedge clk);
        n_vec++;
        if (dut_pulses != p0) begin n_err++; $display("FAIL bounce_strobe: got %0d expected 0", dut_pulses - p0); end
        for (int i = 0; i < 10; i++) begin
            next_tick();
            n_vec++;
            if ({row, key_valid, key_down} !== {e_row, e_valid, e_down}) begin
                n_err++;
                $display("FAIL bounce_step: tick %0d got row=%b valid=%b down=%b expected row=%b valid=%b down=%b",
                         i, row, key_valid, key_down, e_row, e_valid, e_down);
            end
        end
        repeat (3) @(negedge clk);
        n_vec++;
        if ({key, key_down} !== {4'd9, 1'b1} || dut_pulses - p0 != 1) begin
            n_err++; $display("FAIL bounce_accept: got key=%0d down=%b strobes=%0d expected 9/1/1", key, key_down, dut_pulses - p0);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int p0;
        keys = '0;
        repeat (4) next_tick();
        keys = K9;
        do begin next_tick(); n++; end while (!m_locked && n < 8);
        next_tick();
        p0 = dut_pulses;
        repeat (4) @(negedge clk);
        nclr = 1'b0;
        #1;
        n_vec++;
        if ({row, key, key_valid, key_down} !== {4'b1110, 4'd0, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL reset_mid: got row=%b key=%0d valid=%b down=%b expected 1110/0/0/0",
                              row, key, key_valid, key_down);
        end
        keys = '0;
        @(negedge clk);
        nclr = 1'b1;
        next_tick();
        n_vec++;
        if (row !== 4'b1101) begin n_err++; $display("FAIL reset_resume: got %b expected 1101", row); end
        repeat (3) @(negedge clk);
        n_vec++;
        if (dut_pulses != p0) begin n_err++; $display("FAIL reset_strobe: got %0d expected 0", dut_pulses - p0); end
    endtask

    task automatic test_random();
        for (int t = 0; t < 400; t++) begin
            int sel = int'($urandom_range(0, 99));
            if (sel < 15) keys = '0;
            else if (sel < 25) keys = 16'd1 << $urandom_range(0, 15);
            else if (sel < 28) keys = 16'($urandom);
            next_tick();
            n_vec++;
            if ({row, key, key_valid, key_down} !== {e_row, e_key, e_valid, e_down}) begin
                n_err++;
                $display("FAIL random_step: tick %0d got row=%b key=%0d valid=%b down=%b expected row=%b key=%0d valid=%b down=%b",
                         t, row, key, key_valid, key_down, e_row, e_key, e_valid, e_down);
            end
        end
        repeat (3) @(negedge clk);
        n_vec++;
        if (dut_pulses != exp_pulses) begin
            n_err++; $display("FAIL random_strobes: got %0d expected %0d", dut_pulses, exp_pulses);
        end
    endtask

`ifdef KEY_REPEAT_EN
    task automatic test_repeat();
        int q[$];
        keys = '0;
        repeat (6) next_tick();
        keys = K15;
        for (int t = 0; t < 30; t++) begin
            next_tick();
            if (key_valid) begin
                q.push_back(t);
                n_vec++;
                if (key !== 4'd15) begin n_err++; $display("FAIL repeat_key: got %0d expected 15", key); end
            end
            n_vec++;
            if (key_valid !== e_valid) begin n_err++; $display("FAIL repeat_model: tick %0d got %b expected %b", t, key_valid, e_valid); end
        end
        n_vec++;
        if (q.size() < 5) begin
            n_err++; $display("FAIL repeat_count: got %0d strobes expected at least 5", q.size());
        end else begin
            for (int i = 1; i < q.size(); i++) begin
                n_vec++;
                if (q[i] - q[i-1] != (i == 1 ? RD : RR)) begin
                    n_err++; $display("FAIL repeat_gap: strobe %0d got gap %0d expected %0d", i, q[i] - q[i-1], i == 1 ? RD : RR);
                end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_idle_scan();
        test_press();
        test_release_bounce();
        test_bounce();
        test_reset_mid();
        test_random();
`ifdef KEY_REPEAT_EN
        test_repeat();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end
endmodule
